// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared widths, timing sets and FSM type for the raster timing generator
package video_timing_pkg;

  localparam int CNT_W = 11;

  // 640x480@60
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // 1280x720@60, positive syncs
  localparam int HD_H_ACTIVE = 1280;
  localparam int HD_H_FP     = 110;
  localparam int HD_H_SYNC   = 40;
  localparam int HD_H_BP     = 220;
  localparam int HD_V_ACTIVE = 720;
  localparam int HD_V_FP     = 5;
  localparam int HD_V_SYNC   = 5;
  localparam int HD_V_BP     = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one raster axis: wrapping counter plus active/sync decode of its next value
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap,
  output logic             active_nxt,
  output logic             sync_nxt
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (clear) begin
      cnt_nxt = '0;
    end else if (advance) begin
      cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  // Decoding the next value lets the top register flags in step with the counter.
  assign active_nxt = (cnt_nxt < ACT_END);
  assign sync_nxt   = (cnt_nxt >= SYNC_BEG) && (cnt_nxt < SYNC_END);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: counters, syncs, data enable, line/frame strobes
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic [7:0]       o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_width
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end

  run_state_t       state;
  logic             advance;
  logic             clear;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_active;
  logic             v_active;
  logic             h_sync;
  logic             v_sync;

  // The first cycle after leaving IDLE shows the held origin instead of stepping past it.
  assign advance = (state == ST_RUN) && i_enable;
  assign clear   = !i_enable;

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .advance   (advance),
    .cnt       (o_hcnt),
    .cnt_nxt   (h_nxt),
    .wrap      (h_wrap),
    .active_nxt(h_active),
    .sync_nxt  (h_sync)
  );

  timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .advance   (advance && h_wrap),
    .cnt       (o_vcnt),
    .cnt_nxt   (v_nxt),
    .wrap      (v_wrap),
    .active_nxt(v_active),
    .sync_nxt  (v_sync)
  );

  // i_enable is the next FSM state, so the registered flags describe the same cycle as the counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      o_de          <= 1'b0;
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: if (i_enable)  state <= ST_RUN;
        ST_RUN:  if (!i_enable) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      o_de          <= i_enable && h_active && v_active;
      o_hsync       <= (i_enable && h_sync) ? HS_POL : ~HS_POL;
      o_vsync       <= (i_enable && v_sync) ? VS_POL : ~VS_POL;
      o_line_start  <= i_enable && (h_nxt == '0);
      o_frame_start <= i_enable && (h_nxt == '0) && (v_nxt == '0);
      if (advance && h_wrap && v_wrap) begin
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized bench for video_timing_gen against a linear raster-position model
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk;
  logic resetn;
  logic en;

  logic [10:0] obs_h  [3];
  logic [10:0] obs_v  [3];
  logic        obs_hs [3];
  logic        obs_vs [3];
  logic        obs_de [3];
  logic        obs_ls [3];
  logic        obs_fs [3];
  logic [7:0]  obs_fc [3];

  int n_checks = 0;
  int n_errors = 0;

  // config per instance: 0 = 640x480, 1 = 1280x720, 2 = tiny raster for frame-level checks
  int cfg_ha[3], cfg_hf[3], cfg_hsw[3], cfg_hb[3];
  int cfg_va[3], cfg_vf[3], cfg_vsw[3], cfg_vb[3];
  bit cfg_hp[3], cfg_vp[3];

  int pos[3];
  int frames[3];
  bit running[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen u_vga (
    .clk(clk), .resetn(resetn), .i_enable(en),
    .o_hcnt(obs_h[0]), .o_vcnt(obs_v[0]), .o_hsync(obs_hs[0]), .o_vsync(obs_vs[0]),
    .o_de(obs_de[0]), .o_line_start(obs_ls[0]), .o_frame_start(obs_fs[0]), .o_frame_cnt(obs_fc[0])
  );

  video_timing_gen #(
    .H_ACTIVE(HD_H_ACTIVE), .H_FP(HD_H_FP), .H_SYNC(HD_H_SYNC), .H_BP(HD_H_BP),
    .V_ACTIVE(HD_V_ACTIVE), .V_FP(HD_V_FP), .V_SYNC(HD_V_SYNC), .V_BP(HD_V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_hd (
    .clk(clk), .resetn(resetn), .i_enable(en),
    .o_hcnt(obs_h[1]), .o_vcnt(obs_v[1]), .o_hsync(obs_hs[1]), .o_vsync(obs_vs[1]),
    .o_de(obs_de[1]), .o_line_start(obs_ls[1]), .o_frame_start(obs_fs[1]), .o_frame_cnt(obs_fc[1])
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_tiny (
    .clk(clk), .resetn(resetn), .i_enable(en),
    .o_hcnt(obs_h[2]), .o_vcnt(obs_v[2]), .o_hsync(obs_hs[2]), .o_vsync(obs_vs[2]),
    .o_de(obs_de[2]), .o_line_start(obs_ls[2]), .o_frame_start(obs_fs[2]), .o_frame_cnt(obs_fc[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int h_total(input int i);
    return cfg_ha[i] + cfg_hf[i] + cfg_hsw[i] + cfg_hb[i];
  endfunction

  function automatic int v_total(input int i);
    return cfg_va[i] + cfg_vf[i] + cfg_vsw[i] + cfg_vb[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0;
      frames[i] = 0;
      running[i] = 1'b0;
    end
  endtask

  // Raster position is a single index into the frame; h/v fall out by division.
  task automatic model_step(input bit e);
    for (int i = 0; i < 3; i++) begin
      if (!e) begin
        running[i] = 1'b0;
        pos[i] = 0;
      end else if (!running[i]) begin
        running[i] = 1'b1;
      end else begin
        pos[i] = (pos[i] + 1) % (h_total(i) * v_total(i));
        if (pos[i] == 0) frames[i] = (frames[i] + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    int h, v;
    bit hs_on, vs_on;
    for (int i = 0; i < 3; i++) begin
      h = pos[i] % h_total(i);
      v = pos[i] / h_total(i);
      hs_on = running[i] && h >= cfg_ha[i] + cfg_hf[i] && h < cfg_ha[i] + cfg_hf[i] + cfg_hsw[i];
      vs_on = running[i] && v >= cfg_va[i] + cfg_vf[i] && v < cfg_va[i] + cfg_vf[i] + cfg_vsw[i];
      check($sformatf("hcnt[%0d]", i), obs_h[i], h);
      check($sformatf("vcnt[%0d]", i), obs_v[i], v);
      check($sformatf("de[%0d]", i), obs_de[i], running[i] && h < cfg_ha[i] && v < cfg_va[i]);
      check($sformatf("hsync[%0d]", i), obs_hs[i], hs_on ? cfg_hp[i] : !cfg_hp[i]);
      check($sformatf("vsync[%0d]", i), obs_vs[i], vs_on ? cfg_vp[i] : !cfg_vp[i]);
      check($sformatf("line_start[%0d]", i), obs_ls[i], running[i] && h == 0);
      check($sformatf("frame_start[%0d]", i), obs_fs[i], running[i] && pos[i] == 0);
      check($sformatf("frame_cnt[%0d]", i), obs_fc[i], frames[i]);
    end
  endtask

  task automatic cycle(input bit e);
    en = e;
    @(posedge clk);
    model_step(e);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int de_cnt, hs0_cnt, ls_cnt, hs1_cnt, fs2_cnt, ls2_cnt, vs2_cnt;
    logic [7:0] fc_before;
    int tiny_frame;
    bit e;

    cfg_ha  = '{VGA_H_ACTIVE, HD_H_ACTIVE, 8};
    cfg_hf  = '{VGA_H_FP, HD_H_FP, 2};
    cfg_hsw = '{VGA_H_SYNC, HD_H_SYNC, 3};
    cfg_hb  = '{VGA_H_BP, HD_H_BP, 2};
    cfg_va  = '{VGA_V_ACTIVE, HD_V_ACTIVE, 5};
    cfg_vf  = '{VGA_V_FP, HD_V_FP, 1};
    cfg_vsw = '{VGA_V_SYNC, HD_V_SYNC, 2};
    cfg_vb  = '{VGA_V_BP, HD_V_BP, 1};
    cfg_hp  = '{1'b0, 1'b1, 1'b0};
    cfg_vp  = '{1'b0, 1'b1, 1'b0};

    resetn = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all();
    resetn = 1'b1;

    // run to hcnt=300, then assert reset between clock edges
    repeat (301) cycle(1'b1);
    check("pre_reset_hcnt", obs_h[0], 300);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    resetn = 1'b1;

    // first 1650 running cycles cover one full 1280x720 line and two 640x480 lines
    de_cnt = 0; hs0_cnt = 0; ls_cnt = 0; hs1_cnt = 0;
    for (int k = 0; k < 1650; k++) begin
      cycle(1'b1);
      if (k < 800) begin
        de_cnt  += int'(obs_de[0]);
        hs0_cnt += int'(!obs_hs[0]);
        ls_cnt  += int'(obs_ls[0]);
      end
      hs1_cnt += int'(obs_hs[1]);
    end
    check("vga_line_de_clks", de_cnt, 640);
    check("vga_line_hsync_clks", hs0_cnt, 96);
    check("vga_line_start_pulses", ls_cnt, 1);
    check("hd_line_hsync_clks", hs1_cnt, 40);

    // 256 full tiny frames must bring frame_cnt back to where it started
    tiny_frame = h_total(2) * v_total(2);
    fc_before = obs_fc[2];
    fs2_cnt = 0; ls2_cnt = 0; vs2_cnt = 0;
    repeat (256 * tiny_frame) begin
      cycle(1'b1);
      fs2_cnt += int'(obs_fs[2]);
      ls2_cnt += int'(obs_ls[2]);
      vs2_cnt += int'(!obs_vs[2]);
    end
    check("tiny_frame_start_pulses", fs2_cnt, 256);
    check("tiny_line_start_pulses", ls2_cnt, 256 * 9);
    check("tiny_vsync_clks", vs2_cnt, 256 * 2 * 15);
    check("tiny_frame_cnt_wrap", obs_fc[2], fc_before);

    // random enable drops and bursts
    for (int k = 0; k < 3000; k++) begin
      e = ($urandom_range(0, 15) != 0);
      cycle(e);
      if (!e && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) cycle(1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
